array121_wrq: RTL and testbench
===============================

ARRAY121_WRQ -- requirements
Module: array121_wrq

Interface
REQ-001 SHALL have parameters: ADDRBIT, 9, address width; DEPTH, 512, array entries; WIDTH, 32, data width; QDEPTH, 4, write-queue entries (power of 2, >=2).
REQ-002 SHALL have ports:
- wclk  input  1  sole clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- dp_we  input  1  datapath write request, one-cycle, never stalled
- dp_wa  input  ADDRBIT  datapath write address
- dp_di  input  WIDTH  datapath write data
- cpu_req  input  1  CPU write request, held until cpu_ack
- cpu_wa  input  ADDRBIT  CPU write address
- cpu_di  input  WIDTH  CPU write data
- cpu_ack  output  1  one-cycle CPU write accept pulse
- init_req  input  1  one-cycle request to clear whole array
- init_busy  output  1  init engine active
- wr_hold  input  1  downstream inhibit; no array write issued while high
- ovf_clr  input  1  clears ovf_stk
- ovf_stk  output  1  sticky: datapath write dropped
- wa  output  ADDRBIT  array write address, registered
- we  output  1  array write enable, registered
- di  output  WIDTH  array write data, registered

Function
REQ-003 SHALL hold pending writes in a QDEPTH-entry FIFO of {addr, data} with count 0..QDEPTH, evaluated on pre-edge count.
REQ-004 SHALL enqueue dp_we when count<QDEPTH; dp has priority over CPU in the same cycle.
REQ-005 SHALL drop a dp_we arriving with count==QDEPTH and set ovf_stk next cycle; a same-cycle dequeue does not rescue it.
REQ-006 SHALL accept CPU write when cpu_req=1, dp_we=0, count<QDEPTH, FSM in IDLE; cpu_ack pulses 1 cycle later, same edge the entry enters the FIFO.
REQ-007 SHALL not re-accept the same cpu_req in the cycle cpu_ack is high.
REQ-008 SHALL dequeue one entry per cycle when count>0, wr_hold=0, FSM not CLEAR; the following edge drives we=1, wa/di = entry.
REQ-009 SHALL drive we=0 (wa/di hold last value) in any cycle with no dequeue or clear write.
REQ-010 Latency: dp_we at cycle N into empty FIFO, wr_hold=0 -> we=1 at N+1 (bypass via FIFO head, no extra stage).
REQ-011 Simultaneous enqueue and dequeue SHALL leave count unchanged; FIFO order strictly preserved, pointers wrap modulo QDEPTH.
REQ-012 ovf_stk: clr has priority over set when both occur in the same cycle.
REQ-013 Init FSM states IDLE, DRAIN, CLEAR: IDLE->DRAIN on init_req; DRAIN->CLEAR when count==0; CLEAR issues we=1, di=0, wa=0..DEPTH-1 incrementing one per cycle when wr_hold=0 (paused otherwise); after wa=DEPTH-1 issued -> IDLE.
REQ-014 init_busy SHALL be 1 in DRAIN and CLEAR; init_req while busy ignored.
REQ-015 In DRAIN/CLEAR, CPU writes not accepted; dp writes still enqueue (subject to REQ-005) and drain after CLEAR ends.

Reset
REQ-016 rst SHALL force, at next edge: we=0, wa=0, di=0, cpu_ack=0, ovf_stk=0, init_busy=0, count=0, pointers=0, FSM=IDLE, clear counter=0; inputs ignored that cycle.
REQ-017 rst mid-CLEAR SHALL abort clear; no resume.

Configuration
REQ-018 Macro ARRAY121_WRQ_INIT_EN: defined -> init FSM per REQ-013..015, REQ-017; undefined -> no FSM logic, init_busy tied 0, init_req ignored, CPU acceptance depends only on REQ-006 minus FSM term.

Verification
REQ-019 dp_we at cycle 10, wa=0x05, di=0xA5A5A5A5, empty FIFO -> we=1, wa=0x05, di=0xA5A5A5A5 at cycle 11, we=0 at 12.
REQ-020 wr_hold=1; 5 dp_we on consecutive cycles (QDEPTH=4) -> 4 queued, 5th dropped, ovf_stk=1; release hold -> 4 writes in order, back-to-back; ovf_clr -> ovf_stk=0.
REQ-021 cpu_req held with dp_we every cycle for 3 cycles -> cpu_ack only after dp_we drops; CPU write issued after the 3 dp writes.
REQ-022 INIT_EN: 2 entries queued, init_req -> 2 writes drain, then 512 writes wa=0..511 di=0, init_busy low one cycle after wa=511; wr_hold pulse mid-clear pauses without skipping an address.
REQ-023 rst asserted mid-CLEAR at wa=0x100 -> next edge all outputs zero, FSM IDLE; cpu_req accepted thereafter.

Source files
------------

// File: rtl/array121_wrq_if.sv
// rtl/array121_wrq_if.sv - request/array-write bundle between requesters and the write-queue arbiter
interface array121_wrq_if #(
    parameter int ADDRBIT = 9,
    parameter int WIDTH   = 32
);
    logic               dp_we;
    logic [ADDRBIT-1:0] dp_wa;
    logic [WIDTH-1:0]   dp_di;
    logic               cpu_req;
    logic [ADDRBIT-1:0] cpu_wa;
    logic [WIDTH-1:0]   cpu_di;
    logic               cpu_ack;
    logic               init_req;
    logic               init_busy;
    logic               wr_hold;
    logic               ovf_clr;
    logic               ovf_stk;
    logic [ADDRBIT-1:0] wa;
    logic               we;
    logic [WIDTH-1:0]   di;

    modport master (
        output dp_we, dp_wa, dp_di, cpu_req, cpu_wa, cpu_di, init_req, wr_hold, ovf_clr,
        input  cpu_ack, init_busy, ovf_stk, wa, we, di
    );

    modport slave (
        input  dp_we, dp_wa, dp_di, cpu_req, cpu_wa, cpu_di, init_req, wr_hold, ovf_clr,
        output cpu_ack, init_busy, ovf_stk, wa, we, di
    );
endinterface

// File: rtl/array121_wrq.sv
// rtl/array121_wrq.sv - datapath/CPU array write queue with optional clear engine
// Optional array-clear FSM enabled by macro ARRAY121_WRQ_INIT_EN.
module array121_wrq #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int QDEPTH  = 4
) (
    input logic           wclk,
    input logic           rst,
    array121_wrq_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0]      FULL_CNT  = CW'(QDEPTH);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    logic [ADDRBIT-1:0] qa_q [QDEPTH];
    logic [WIDTH-1:0]   qd_q [QDEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               we_q, we_d;
    logic [ADDRBIT-1:0] wa_q, wa_d;
    logic [WIDTH-1:0]   di_q, di_d;
    logic               cpu_ack_q, ovf_q, ovf_d;

    logic               fsm_idle, fsm_clear;
    logic [ADDRBIT-1:0] clr_addr;
    logic               full, drop, cpu_acc, enq, deq, clr_fire;
    logic [ADDRBIT-1:0] enq_addr, head_addr;
    logic [WIDTH-1:0]   enq_data, head_data;

    // An empty queue forwards the incoming request straight to the array port.
    always_comb begin
        full      = (count_q == FULL_CNT);
        drop      = bus.dp_we && full;
        cpu_acc   = bus.cpu_req && !bus.dp_we && !full && fsm_idle && !cpu_ack_q;
        enq       = (bus.dp_we && !full) || cpu_acc;
        enq_addr  = bus.dp_we ? bus.dp_wa : bus.cpu_wa;
        enq_data  = bus.dp_we ? bus.dp_di : bus.cpu_di;
        head_addr = (count_q == '0) ? enq_addr : qa_q[rptr_q];
        head_data = (count_q == '0) ? enq_data : qd_q[rptr_q];
        deq       = ((count_q != '0) || enq) && !bus.wr_hold && !fsm_clear;
        clr_fire  = fsm_clear && !bus.wr_hold;
        count_d   = count_q + CW'(enq) - CW'(deq);
        ovf_d     = bus.ovf_clr ? 1'b0 : (ovf_q || drop);
    end

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        di_d = di_q;
        if (clr_fire) begin
            we_d = 1'b1;
            wa_d = clr_addr;
            di_d = '0;
        end else if (deq) begin
            we_d = 1'b1;
            wa_d = head_addr;
            di_d = head_data;
        end
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            di_q      <= '0;
            cpu_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (enq) begin
                qa_q[wptr_q] <= enq_addr;
                qd_q[wptr_q] <= enq_data;
                wptr_q       <= wptr_q + PW'(1);
            end
            if (deq) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q   <= count_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            di_q      <= di_d;
            cpu_ack_q <= cpu_acc;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ARRAY121_WRQ_INIT_EN
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    state_e             state_q, state_d;
    logic [ADDRBIT-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE:  if (bus.init_req) state_d = DRAIN;
            DRAIN: if (count_q == '0) state_d = CLEAR;
            CLEAR: begin
                if (!bus.wr_hold) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDRBIT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign fsm_idle      = (state_q == IDLE);
    assign fsm_clear     = (state_q == CLEAR);
    assign clr_addr      = clr_cnt_q;
    assign bus.init_busy = !fsm_idle;
`else
    logic unused_init;

    assign unused_init   = bus.init_req | (&LAST_ADDR);
    assign fsm_idle      = 1'b1;
    assign fsm_clear     = 1'b0;
    assign clr_addr      = '0;
    assign bus.init_busy = 1'b0;
`endif

    assign bus.we      = we_q;
    assign bus.wa      = wa_q;
    assign bus.di      = di_q;
    assign bus.cpu_ack = cpu_ack_q;
    assign bus.ovf_stk = ovf_q;
endmodule

// File: tb/tb_array121_wrq.sv
// tb/tb_array121_wrq.sv - directed table-driven bench for array121_wrq
module tb_array121_wrq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    array121_wrq_if bus ();
    array121_wrq dut (.wclk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        dp_we;
        logic [8:0]  dp_wa;
        logic [31:0] dp_di;
        logic        cpu_req;
        logic        hold;
        logic        oclr;
        logic        e_we;
        logic [8:0]  e_wa;
        logic [31:0] e_di;
        logic        e_ack;
        logic        e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int dw, input int a, input int d, input int c, input int h,
                       input int o, input int ew, input int ea, input int ed, input int ek,
                       input int eo);
        vec_t v;
        v.dp_we   = dw[0];
        v.dp_wa   = 9'(a);
        v.dp_di   = 32'(d);
        v.cpu_req = c[0];
        v.hold    = h[0];
        v.oclr    = o[0];
        v.e_we    = ew[0];
        v.e_wa    = 9'(ea);
        v.e_di    = 32'(ed);
        v.e_ack   = ek[0];
        v.e_ovf   = eo[0];
        vq.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic quiet;
        bus.dp_we    = 1'b0;
        bus.dp_wa    = '0;
        bus.dp_di    = '0;
        bus.cpu_req  = 1'b0;
        bus.init_req = 1'b0;
        bus.wr_hold  = 1'b0;
        bus.ovf_clr  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        int errs;
        int steps;
        bit paused;

        quiet();
        bus.cpu_wa = 9'h040;
        bus.cpu_di = 32'hC0C0_C0C0;
        bus.dp_we  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_wa", 32'(bus.wa), 0);
        chk("rst_di", bus.di, 0);
        chk("rst_ack", 32'(bus.cpu_ack), 0);
        chk("rst_ovf", 32'(bus.ovf_stk), 0);
        chk("rst_busy", 32'(bus.init_busy), 0);
        rst = 1'b0;
        quiet();

        // dp_we cpu wa di hold clr | we wa di ack ovf
        add(0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0);
        add(1, 'h05, 'hA5A5A5A5, 0, 0, 0, 1, 'h05, 'hA5A5A5A5, 0, 0);
        add(0, 0, 0, 0, 0, 0,        0, 'h05, 'hA5A5A5A5, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 'h10 + i, i + 1, 0, 1, 0, 0, 'h05, 'hA5A5A5A5, 0, 0);
        add(1, 'h14, 5, 0, 1, 0,     0, 'h05, 'hA5A5A5A5, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'h10 + i, i + 1, 0, 1);
        add(0, 0, 0, 0, 0, 0,        0, 'h13, 4, 0, 1);
        add(0, 0, 0, 0, 0, 1,        0, 'h13, 4, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 'h20 + i, 'h20 + i, 0, 1, 0, 0, 'h13, 4, 0, 0);
        add(1, 'h24, 'h24, 0, 0, 0,  1, 'h20, 'h20, 0, 1);
        add(1, 'h25, 'h25, 0, 0, 1,  1, 'h21, 'h21, 0, 0);
        add(0, 0, 0, 0, 0, 0,        1, 'h22, 'h22, 0, 0);
        add(0, 0, 0, 0, 0, 0,        1, 'h23, 'h23, 0, 0);
        add(0, 0, 0, 0, 0, 0,        1, 'h25, 'h25, 0, 0);
        add(0, 0, 0, 0, 0, 0,        0, 'h25, 'h25, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 'h30 + i, 'h30 + i, 0, 1, 0, 0, 'h25, 'h25, 0, 0);
        add(1, 'h34, 'h34, 0, 1, 1,  0, 'h25, 'h25, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'h30 + i, 'h30 + i, 0, 0);
        add(0, 0, 0, 0, 0, 0,        0, 'h33, 'h33, 0, 0);
        for (int i = 1; i < 4; i++) add(1, 'h40 + i, 'h40 + i, 1, 0, 0, 1, 'h40 + i, 'h40 + i, 0, 0);
        add(0, 0, 0, 1, 0, 0,        1, 'h40, 'hC0C0C0C0, 1, 0);
        add(0, 0, 0, 1, 0, 0,        0, 'h40, 'hC0C0C0C0, 0, 0);
        add(0, 0, 0, 0, 0, 0,        0, 'h40, 'hC0C0C0C0, 0, 0);

        foreach (vq[i]) begin
            bus.dp_we   = vq[i].dp_we;
            bus.dp_wa   = vq[i].dp_wa;
            bus.dp_di   = vq[i].dp_di;
            bus.cpu_req = vq[i].cpu_req;
            bus.wr_hold = vq[i].hold;
            bus.ovf_clr = vq[i].oclr;
            tick();
            chk($sformatf("v%0d_we", i), 32'(bus.we), 32'(vq[i].e_we));
            chk($sformatf("v%0d_wa", i), 32'(bus.wa), 32'(vq[i].e_wa));
            chk($sformatf("v%0d_di", i), bus.di, vq[i].e_di);
            chk($sformatf("v%0d_ack", i), 32'(bus.cpu_ack), 32'(vq[i].e_ack));
            chk($sformatf("v%0d_ovf", i), 32'(bus.ovf_stk), 32'(vq[i].e_ovf));
        end
        quiet();

`ifdef ARRAY121_WRQ_INIT_EN
        // Two queued writes drain ahead of the clear sweep.
        bus.wr_hold = 1'b1;
        bus.dp_we   = 1'b1;
        bus.dp_wa   = 9'h050;
        bus.dp_di   = 32'h50;
        tick();
        bus.dp_wa   = 9'h051;
        bus.dp_di   = 32'h51;
        tick();
        chk("pre_init_we", 32'(bus.we), 0);
        quiet();
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        chk("drain0_we", 32'(bus.we), 1);
        chk("drain0_wa", 32'(bus.wa), 'h50);
        chk("drain0_busy", 32'(bus.init_busy), 1);
        tick();
        chk("drain1_wa", 32'(bus.wa), 'h51);
        chk("drain1_di", bus.di, 'h51);
        tick();
        chk("to_clear_we", 32'(bus.we), 0);
        chk("to_clear_busy", 32'(bus.init_busy), 1);

        a = 0; errs = 0; steps = 0; paused = 1'b0;
        while (a < 512 && steps < 1200) begin
            bus.wr_hold  = (a == 100 && !paused);
            bus.dp_we    = (a == 200);
            bus.dp_wa    = 9'h060;
            bus.dp_di    = 32'h66;
            bus.init_req = (a == 300);
            bus.cpu_req  = (a == 400);
            tick();
            steps++;
            if (bus.wr_hold) begin
                paused = 1'b1;
                if (bus.we !== 1'b0) errs++;
            end else begin
                if (bus.we !== 1'b1 || bus.wa !== 9'(a) || bus.di !== 32'h0) errs++;
                a++;
            end
            if (bus.cpu_ack !== 1'b0) errs++;
            if (a < 512 && bus.init_busy !== 1'b1) errs++;
        end
        quiet();
        chk("clear_seq_errs", errs, 0);
        chk("clear_addr_count", a, 512);
        chk("clear_last_wa", 32'(bus.wa), 'h1FF);
        chk("busy_after_clear", 32'(bus.init_busy), 0);
        tick();
        chk("post_clear_we", 32'(bus.we), 1);
        chk("post_clear_wa", 32'(bus.wa), 'h60);
        chk("post_clear_di", bus.di, 'h66);
        tick();
        chk("post_clear_idle", 32'(bus.we), 0);

        // Reset in the middle of a clear sweep.
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) tick();
        chk("mid_clear_wa", 32'(bus.wa), 'hFF);
        chk("mid_clear_busy", 32'(bus.init_busy), 1);
        rst = 1'b1;
        bus.dp_we = 1'b1;
        bus.dp_wa = 9'h1FF;
        bus.dp_di = 32'hDEAD;
        tick();
        rst = 1'b0;
        quiet();
        chk("abort_we", 32'(bus.we), 0);
        chk("abort_wa", 32'(bus.wa), 0);
        chk("abort_di", bus.di, 0);
        chk("abort_busy", 32'(bus.init_busy), 0);
        chk("abort_ovf", 32'(bus.ovf_stk), 0);
        tick();
        chk("no_resume_we", 32'(bus.we), 0);
        chk("no_resume_busy", 32'(bus.init_busy), 0);
        bus.cpu_req = 1'b1;
        bus.cpu_wa  = 9'h077;
        bus.cpu_di  = 32'h1234_5678;
        tick();
        bus.cpu_req = 1'b0;
        chk("after_abort_ack", 32'(bus.cpu_ack), 1);
        chk("after_abort_we", 32'(bus.we), 1);
        chk("after_abort_wa", 32'(bus.wa), 'h77);
        chk("after_abort_di", bus.di, 32'h1234_5678);
        tick();
        chk("after_abort_ack_end", 32'(bus.cpu_ack), 0);
`else
        bus.init_req = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_wa   = 9'h077;
        bus.cpu_di   = 32'h1234_5678;
        tick();
        quiet();
        chk("noinit_busy", 32'(bus.init_busy), 0);
        chk("noinit_ack", 32'(bus.cpu_ack), 1);
        chk("noinit_wa", 32'(bus.wa), 'h77);
        tick();
        chk("noinit_busy2", 32'(bus.init_busy), 0);
        chk("noinit_we2", 32'(bus.we), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
